// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants and instruction-format classification,
// used by the encoder and the immediate decoder.
package riscv_pkg;

    localparam logic [6:0] OP_LW        = 7'b0000011;
    localparam logic [6:0] OP_SW        = 7'b0100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_IMMEDIATE = 7'b0010011;
    localparam logic [6:0] OP_RTYPE     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R,
        FMT_BAD
    } fmt_t;

    function automatic fmt_t fmt_of(input logic [6:0] op);
        case (op)
            OP_IMMEDIATE, OP_LW, OP_JALR: return FMT_I;
            OP_SW:                        return FMT_S;
            OP_BRANCH:                    return FMT_B;
            OP_LUI, OP_AUIPC:             return FMT_U;
            OP_JAL:                       return FMT_J;
            OP_RTYPE:                     return FMT_R;
            default:                      return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational check that an immediate fits the field of its instruction
// format (including the even-offset rule for branches and jumps).
module imm_range_check
    import riscv_pkg::*;
(
    input  fmt_t               fmt,
    input  logic signed [31:0] imm,
    output logic               bad
);

    always_comb begin
        bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: bad = (imm < -32'sd2048) || (imm > 32'sd2047);
            FMT_B:        bad = (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
            FMT_J:        bad = (imm < -32'sd1048576) || (imm > 32'sd1048574) || imm[0];
            FMT_U:        bad = |imm[11:0];
            default:      bad = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a single ready/valid output register.
// Define ENCODER_RANGE_CHECK_EN to flag immediates that do not fit their field.
module instr_encoder
    import riscv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [6:0]         opcode_i,
    input  logic [4:0]         rd_i,
    input  logic [4:0]         rs1_i,
    input  logic [4:0]         rs2_i,
    input  logic [2:0]         funct3_i,
    input  logic [6:0]         funct7_i,
    input  logic signed [31:0] imm_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [31:0]        instr_o,
    output logic               err_o,
    output logic [15:0]        count_o
);

    fmt_t               fmt;
    logic [31:0]        instr_p0;
    logic               err_p0;
    logic               range_bad;
    logic               vld_p1;
    logic [31:0]        instr_p1;
    logic               err_p1;
    logic [15:0]        beat_cnt;

    function automatic logic [31:0] pack(
        input fmt_t        f,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        case (f)
            FMT_I:   return {imm[11:0], rs1, f3, rd, op};
            FMT_S:   return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   return {imm[31:12], rd, op};
            FMT_J:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            FMT_R:   return {f7, rs2, rs1, f3, rd, op};
            default: return 32'h0000_0000;
        endcase
    endfunction

`ifdef ENCODER_RANGE_CHECK_EN
    imm_range_check u_range (
        .fmt (fmt),
        .imm (imm_i),
        .bad (range_bad)
    );
`else
    assign range_bad = 1'b0;
`endif

    // stage p0: combinational packing of the request fields
    assign fmt      = fmt_of(opcode_i);
    assign instr_p0 = pack(fmt, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
    assign err_p0   = (fmt == FMT_BAD) || range_bad;

    assign ready_o = !vld_p1 || ready_i;

    // stage p1: output register; data is cleared too so reset shows zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            instr_p1 <= 32'h0000_0000;
            err_p1   <= 1'b0;
            beat_cnt <= 16'h0000;
        end else begin
            if (valid_i && ready_o) begin
                vld_p1   <= 1'b1;
                instr_p1 <= instr_p0;
                err_p1   <= err_p0;
            end else if (ready_i) begin
                vld_p1   <= 1'b0;
            end
            if (vld_p1 && ready_i) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

    assign valid_o = vld_p1;
    assign instr_o = instr_p1;
    assign err_o   = err_p1;
    assign count_o = beat_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a field-level reference model feeds an
// expectation queue that an independent monitor drains on every output beat.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic        err_o;
    logic [15:0] count_o;

    int          tests = 0;
    int          fails = 0;
    logic [32:0] q[$];
    logic [15:0] exp_cnt = 16'h0000;
    logic        rand_ready = 1'b0;

    instr_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .opcode_i (opcode_i),
        .rd_i     (rd_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .imm_i    (imm_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .instr_o  (instr_o),
        .err_o    (err_o),
        .count_o  (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: places each field at its bit position arithmetically.
    function automatic logic [32:0] exp_of(
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] o, d, a, b, c, g, w;
        int si;
        logic bad, rng;
        o = 32'(op); d = 32'(rd); a = 32'(rs1); b = 32'(rs2); c = 32'(f3); g = 32'(f7);
        si = int'($signed(imm));
        bad = 1'b0; rng = 1'b0; w = 32'h0;
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w = ((imm & 32'hFFF) << 20) | (a << 15) | (c << 12) | (d << 7) | o;
                rng = (si < -2048) || (si > 2047);
            end
            7'b0100011: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (c << 12)
                    | ((imm & 32'h1F) << 7) | o;
                rng = (si < -2048) || (si > 2047);
            end
            7'b1100011: begin
                w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (b << 20)
                    | (a << 15) | (c << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 32'h1) << 7) | o;
                rng = (si < -4096) || (si > 4094) || (si % 2 != 0);
            end
            7'b0110111, 7'b0010111: begin
                w = (imm & 32'hFFFF_F000) | (d << 7) | o;
                rng = (imm & 32'hFFF) != 0;
            end
            7'b1101111: begin
                w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (d << 7) | o;
                rng = (si < -1048576) || (si > 1048574) || (si % 2 != 0);
            end
            7'b0110011: w = (g << 25) | (b << 20) | (a << 15) | (c << 12) | (d << 7) | o;
            default: bad = 1'b1;
        endcase
`ifdef ENCODER_RANGE_CHECK_EN
        return {bad | rng, w};
`else
        return {bad, w};
`endif
    endfunction

    // Monitor: pops on output transfers, pushes on input transfers
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst) begin
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got instr %h, expected no beat", instr_o);
                end else begin
                    e = q.pop_front();
                    chk("beat_instr", instr_o, e[31:0]);
                    chk("beat_err", 32'(err_o), 32'(e[32]));
                    chk("beat_count", 32'(count_o), 32'(exp_cnt));
                end
                exp_cnt = exp_cnt + 16'd1;
            end
            if (valid_i && ready_o)
                q.push_back(exp_of(opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ready_i = ($urandom % 4) != 0;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        logic acc;
        int n;
        opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
        valid_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        valid_i = 1'b0;
    endtask

    initial begin
        logic [32:0] e;
        logic [31:0] dimm;
        logic [15:0] hold;
        logic [31:0] bnd[16];
        int n;
        bnd = '{32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F7FF,
                32'hFFFF_F000, 32'h0000_0FFE, 32'h0000_0FFF, 32'h0000_1000,
                32'hFFFF_EFFE, 32'hFFF0_0000, 32'h000F_FFFE, 32'h0010_0000,
                32'hFFEF_FFFE, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        opcode_i = 7'h0; rd_i = 5'h0; rs1_i = 5'h0; rs2_i = 5'h0;
        funct3_i = 3'h0; funct7_i = 7'h0; imm_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        rst = 1'b0;
        step;

        // addi x1,x2,-1
        ready_i = 1'b1;
        send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("addi_valid", 32'(valid_o), 32'd1);
        chk("addi_instr", instr_o, 32'hFFF1_0093);
        chk("addi_err", 32'(err_o), 32'd0);
        step;

        // jal x0,-4 and decode the immediate back
        send(7'b1101111, 5'd0, 5'd7, 5'd9, 3'd5, 7'd3, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("jal_instr", instr_o, 32'hFFDF_F06F);
        dimm = {{11{instr_o[31]}}, instr_o[31], instr_o[19:12], instr_o[20], instr_o[30:21], 1'b0};
        chk("jal_decode", dimm, 32'hFFFF_FFFC);
        step;

        // addi with out-of-range immediate 2048
        send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        @(negedge clk);
        chk("addi2048_instr", instr_o, 32'h8001_0093);
`ifdef ENCODER_RANGE_CHECK_EN
        chk("addi2048_err", 32'(err_o), 32'd1);
`else
        chk("addi2048_err", 32'(err_o), 32'd0);
`endif
        step;

        // illegal opcode
        send(7'b1111111, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("badop_instr", instr_o, 32'h0);
        chk("badop_err", 32'(err_o), 32'd1);
        step;

        // backpressure: beat held for three cycles
        ready_i = 1'b0;
        send(7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'h1234_5678);
        e = exp_of(7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'h1234_5678);
        hold = exp_cnt;
        repeat (3) begin
            @(negedge clk);
            chk("stall_instr", instr_o, e[31:0]);
            chk("stall_valid", 32'(valid_o), 32'd1);
            chk("stall_ready", 32'(ready_o), 32'd0);
            chk("stall_count", 32'(count_o), 32'(hold));
        end
        step;
        ready_i = 1'b1;
        step;
        chk("stall_release_count", 32'(count_o), 32'(hold + 16'd1));

        // randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [6:0] op;
            logic [31:0] imm;
            logic [6:0] ops[9];
            ops = '{7'b0000011, 7'b0100011, 7'b1101111, 7'b0110111, 7'b1100111,
                    7'b0010111, 7'b1100011, 7'b0010011, 7'b0110011};
            if ($urandom % 7 == 0) op = 7'($urandom);
            else op = ops[$urandom % 9];
            case ($urandom % 4)
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = bnd[$urandom % 16];
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            if ($urandom % 5 == 0) step;
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
        end
        rand_ready = 1'b0;
        step;
        ready_i = 1'b1;
        n = 0;
        while ((q.size() != 0 || valid_o) && n < 100) begin
            step;
            n++;
        end
        chk("drain_queue", 32'(q.size()), 32'd0);

        // reset while a beat is stalled
        ready_i = 1'b0;
        send(7'b0010011, 5'd9, 5'd8, 5'd0, 3'd4, 7'd0, 32'h0000_0055);
        rst = 1'b1;
        #1;
        q.delete();
        exp_cnt = 16'h0000;
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_count", 32'(count_o), 32'd0);
        chk("midrst_ready", 32'(ready_o), 32'd1);
        step;
        rst = 1'b0;
        ready_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("postrst_no_beat", 32'(valid_o), 32'd0);
        end
        step;

        // 65536 back-to-back beats wrap the counter to zero
        opcode_i = 7'b1111111;
        valid_i = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        valid_i = 1'b0;
        step;
        chk("wrap_count", 32'(count_o), 32'd0);
        chk("wrap_idle", 32'(valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
